hram_access_seq: RTL
====================

Name: hram_access_seq

Overview:
- Sequencer for one 127-byte DMG static RAM block (HRAM-style, 128 locations addressed by 7 bits).
- Sits directly upstream of the eight SRAM bit lanes and the row decoder.
- Accepts a byte read/write request and drives the precharge, wordline, column-select, output-enable and write strobes in a fixed cycle sequence.
- Captures read data from the lane data bus and returns it with a one-cycle acknowledge.

Parameters:
- WL_CYCLES, 1, cycles the wordline is held before the transfer cycle (1..4).
- PCH_CYCLES, 2, minimum consecutive precharge cycles required before an access is accepted (1..7).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- n_res  in  1  asynchronous active-low reset.
- req  in  1  access request, sampled in IDLE only.
- we  in  1  1 = write, 0 = read; latched at acceptance.
- addr  in  7  byte address: [6:2] row, [1:0] column; latched at acceptance.
- wdata  in  8  write data, latched at acceptance.
- rdata  out  8  read data register.
- ack  out  1  one-cycle pulse when an access completes.
- busy  out  1  high in every state except IDLE.
- n_pch  out  1  bitline precharge, active low.
- n_wl_pch  out  1  row-decoder precharge, active low.
- wl_ena  out  1  wordline enable to the row decoder.
- row_d  out  5  row address, true rail.
- row_nd  out  5  row address, complement rail.
- col  out  4  one-hot column select.
- oe  out  1  lane read enable.
- n_oe  out  1  complement of oe.
- wr  out  1  lane write strobe.
- db_out  out  8  write data to the lanes; valid while wr = 1.
- db_in  in  8  lane data bus; valid during the READ cycle.

Behaviour:
- States: IDLE, SETUP, WL, XFER, REC.
- Reset (asynchronous, n_res = 0):
  - State goes to IDLE immediately.
  - Outputs: n_pch = 0, n_wl_pch = 0, wl_ena = 0, row_d = 0, row_nd = 0, col = 0, oe = 0, n_oe = 1, wr = 0, db_out = 0, rdata = 0x00, ack = 0, busy = 0.
  - Precharge counter pcnt = 0.
- Precharge counter (pcnt, 3 bits):
  - Increments, saturating at 7, at the end of each cycle in which n_pch = 0.
  - Cleared when n_pch = 1.
- IDLE:
  - n_pch = 0, n_wl_pch = 0; all strobes off.
  - If req = 1 and pcnt >= PCH_CYCLES: latch we, addr and wdata, then go to SETUP.
  - Otherwise stay in IDLE; a req presented while precharge is incomplete is simply not yet accepted.
- SETUP (1 cycle):
  - n_pch = 1, n_wl_pch = 1.
  - row_d = addr[6:2], row_nd = ~addr[6:2].
  - col = 1 << addr[1:0].
  - wl_ena = 0.
- WL (WL_CYCLES cycles, down-counter):
  - SETUP signals held; wl_ena = 1.
- XFER (1 cycle):
  - wl_ena and col held.
  - Read: oe = 1, n_oe = 0; rdata <= db_in at the closing edge.
  - Write: wr = 1, db_out = wdata; rdata is unchanged.
- REC (1 cycle):
  - wl_ena = 0, col = 0, oe = 0, wr = 0.
  - n_pch = 0, n_wl_pch = 0; row_d and row_nd return to 0.
  - ack = 1.
  - Next state is IDLE unconditionally.
- Reserved address 0x7F (IE register, not present in the array):
  - Accepted normally and follows the same state sequence and timing.
  - wl_ena, col, oe and wr are never asserted.
  - A read loads rdata = 0xFF in XFER; a write is discarded.
- Latency with defaults:
  - Request accepted at cycle N → ack at cycle N+3+WL_CYCLES (N+4).
  - Next acceptance is possible no earlier than N+4+PCH_CYCLES (N+6).
  - After reset release, the first acceptance is possible at cycle PCH_CYCLES.
- Invariants:
  - wl_ena = 1 never coincides with n_pch = 0.
  - oe and wr are never both 1.
  - col is zero or one-hot.
  - row_d and row_nd are complementary whenever wl_ena = 1.
- Inputs other than req are ignored outside IDLE.
- Reset asserted mid-access aborts it: no ack is issued, the array contents at that location are undefined, and the bench must not check them.

Test Plan:
- Reset check: hold n_res = 0 → every output matches its listed reset value; release → first accept at cycle 2 with req held.
- Write then read: write 0x42 to 0x05 → row_d = 0x01, row_nd = 0x1E, col = 0010, wr high 1 cycle with db_out = 0x42. Read 0x05 with db_in = 0x42 → oe high 1 cycle, rdata = 0x42, ack 4 cycles after acceptance.
- Reserved address: read 0x7F → wl_ena, col and oe stay 0; rdata = 0xFF; ack at the normal time. Write 0x7F → wr stays 0.
- Back-to-back: req held high for 3 reads → acceptances spaced exactly 6 cycles apart; n_pch low for at least 2 cycles between wordline pulses.
- Abort: assert n_res during WL → n_pch = 0 and wl_ena = 0 immediately; no ack; busy = 0.
- Parameter sweep: WL_CYCLES = 3, PCH_CYCLES = 1 → wl_ena high for 4 cycles (3 in WL plus XFER); ack at acceptance+6; acceptance period 7.

Source files
------------

// File: rtl/hram_access_seq_if.sv
// Request, response and SRAM lane/row-decoder signals of the HRAM access sequencer.
// The slave modport is the sequencer; the master modport is its environment (requester plus array).
interface hram_access_seq_if;
    logic       req;
    logic       we;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       ack;
    logic       busy;
    logic       n_pch;
    logic       n_wl_pch;
    logic       wl_ena;
    logic [4:0] row_d;
    logic [4:0] row_nd;
    logic [3:0] col;
    logic       oe;
    logic       n_oe;
    logic       wr;
    logic [7:0] db_out;
    logic [7:0] db_in;

    modport master (
        output req, we, addr, wdata, db_in,
        input  rdata, ack, busy, n_pch, n_wl_pch, wl_ena, row_d, row_nd, col, oe, n_oe, wr, db_out
    );

    modport slave (
        input  req, we, addr, wdata, db_in,
        output rdata, ack, busy, n_pch, n_wl_pch, wl_ena, row_d, row_nd, col, oe, n_oe, wr, db_out
    );
endinterface

// File: rtl/hram_access_seq.sv
// Byte access sequencer for the 128-location DMG HRAM block: drives precharge, wordline,
// column-select and lane strobes in a fixed SETUP/WL/XFER/REC sequence with registered outputs.
module hram_access_seq #(
    parameter int WL_CYCLES  = 1,
    parameter int PCH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               n_res,
    hram_access_seq_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WL,
        XFER,
        REC
    } state_t;

    localparam logic [2:0] PCH_MIN = 3'(PCH_CYCLES);
    localparam logic [1:0] WL_LOAD = 2'(WL_CYCLES - 1);
    localparam logic [6:0] IE_ADDR = 7'h7F;

    state_t     state_q;
    logic [2:0] pcnt_q, pcnt_d;
    logic [1:0] wlCnt_q;
    logic       we_q;
    logic [6:0] addr_q;
    logic [7:0] wdata_q;

    logic [7:0] rdata_q;
    logic       ack_q;
    logic       busy_q;
    logic       nPch_q;
    logic       nWlPch_q;
    logic       wlEna_q;
    logic [4:0] rowD_q;
    logic [4:0] rowNd_q;
    logic [3:0] col_q;
    logic       oe_q;
    logic       nOe_q;
    logic       wr_q;
    logic [7:0] dbOut_q;

    logic       accept;
    logic       reqIsIe;
    logic       latchedIsIe;

    // The precharge counter tracks how long the bitlines have been precharged, saturating at 7.
    always_comb begin
        pcnt_d = pcnt_q;
        if (nPch_q) begin
            pcnt_d = '0;
        end else if (pcnt_q != 3'd7) begin
            pcnt_d = pcnt_q + 3'd1;
        end
    end

    assign accept      = bus.req && (pcnt_q >= PCH_MIN);
    assign reqIsIe     = (bus.addr == IE_ADDR);
    assign latchedIsIe = (addr_q == IE_ADDR);

    // The IE address walks the normal timing but never touches the array strobes.
    always_ff @(posedge clk or negedge n_res) begin
        if (!n_res) begin
            state_q  <= IDLE;
            pcnt_q   <= '0;
            wlCnt_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            nPch_q   <= 1'b0;
            nWlPch_q <= 1'b0;
            wlEna_q  <= 1'b0;
            rowD_q   <= '0;
            rowNd_q  <= '0;
            col_q    <= '0;
            oe_q     <= 1'b0;
            nOe_q    <= 1'b1;
            wr_q     <= 1'b0;
            dbOut_q  <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q  <= SETUP;
                        we_q     <= bus.we;
                        addr_q   <= bus.addr;
                        wdata_q  <= bus.wdata;
                        busy_q   <= 1'b1;
                        nPch_q   <= 1'b1;
                        nWlPch_q <= 1'b1;
                        rowD_q   <= bus.addr[6:2];
                        rowNd_q  <= ~bus.addr[6:2];
                        col_q    <= reqIsIe ? 4'b0000 : (4'b0001 << bus.addr[1:0]);
                    end
                end
                SETUP: begin
                    state_q <= WL;
                    wlCnt_q <= WL_LOAD;
                    wlEna_q <= !latchedIsIe;
                end
                WL: begin
                    if (wlCnt_q == 2'd0) begin
                        state_q <= XFER;
                        if (!latchedIsIe) begin
                            if (we_q) begin
                                wr_q    <= 1'b1;
                                dbOut_q <= wdata_q;
                            end else begin
                                oe_q  <= 1'b1;
                                nOe_q <= 1'b0;
                            end
                        end
                    end else begin
                        wlCnt_q <= wlCnt_q - 2'd1;
                    end
                end
                XFER: begin
                    state_q <= REC;
                    if (!we_q) begin
                        rdata_q <= latchedIsIe ? 8'hFF : bus.db_in;
                    end
                    ack_q    <= 1'b1;
                    wlEna_q  <= 1'b0;
                    col_q    <= '0;
                    oe_q     <= 1'b0;
                    nOe_q    <= 1'b1;
                    wr_q     <= 1'b0;
                    dbOut_q  <= '0;
                    nPch_q   <= 1'b0;
                    nWlPch_q <= 1'b0;
                    rowD_q   <= '0;
                    rowNd_q  <= '0;
                end
                REC: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.ack      = ack_q;
    assign bus.busy     = busy_q;
    assign bus.n_pch    = nPch_q;
    assign bus.n_wl_pch = nWlPch_q;
    assign bus.wl_ena   = wlEna_q;
    assign bus.row_d    = rowD_q;
    assign bus.row_nd   = rowNd_q;
    assign bus.col      = col_q;
    assign bus.oe       = oe_q;
    assign bus.n_oe     = nOe_q;
    assign bus.wr       = wr_q;
    assign bus.db_out   = dbOut_q;

endmodule
